// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, types and the round helper functions
// (big/small sigma, Ch, Maj) used by the compression engine.
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ROUNDS = 64;

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam word_t IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: working variables a..h in, next a..h out.
module sha256_round
  import sha256_pkg::*;
(
  input  word_t a_i,
  input  word_t b_i,
  input  word_t c_i,
  input  word_t d_i,
  input  word_t e_i,
  input  word_t f_i,
  input  word_t g_i,
  input  word_t h_i,
  input  word_t k_i,
  input  word_t w_i,
  output word_t a_o,
  output word_t b_o,
  output word_t c_o,
  output word_t d_o,
  output word_t e_o,
  output word_t f_o,
  output word_t g_o,
  output word_t h_o
);

  word_t t1;
  word_t t2;

  always_comb begin
    t1 = h_i + big_sigma1(e_i) + ch(e_i, f_i, g_i) + k_i + w_i;
    t2 = big_sigma0(a_i) + maj(a_i, b_i, c_i);
  end

  assign a_o = t1 + t2;
  assign b_o = a_i;
  assign c_o = b_i;
  assign d_o = c_i;
  assign e_o = d_i + t1;
  assign f_o = e_i;
  assign g_o = f_i;
  assign h_o = g_i;

endmodule

// File: rtl/sha256_compress.sv
// Iterative SHA-256 compression: one round per clock, rolling 16-word
// message schedule window, feed-forward add on the final round.
module sha256_compress
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_state,
  input  logic [511:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_digest
);

  // Ascending packed ranges put word 0 (a / W0) in the MSBs, matching the port order.
  state_t              state_q, state_d;
  logic [5:0]          t_q, t_d;
  logic [0:7][31:0]    h_in_q, h_in_d;
  logic [0:7][31:0]    vars_q, vars_d;
  logic [0:15][31:0]   win_q, win_d;
  logic [0:7][31:0]    digest_q, digest_d;
  logic                out_valid_q, out_valid_d;
  logic [0:7][31:0]    rnd;
  word_t               w_new;

  sha256_round u_round (
    .a_i (vars_q[0]), .b_i (vars_q[1]), .c_i (vars_q[2]), .d_i (vars_q[3]),
    .e_i (vars_q[4]), .f_i (vars_q[5]), .g_i (vars_q[6]), .h_i (vars_q[7]),
    .k_i (K[t_q]),
    .w_i (win_q[0]),
    .a_o (rnd[0]), .b_o (rnd[1]), .c_o (rnd[2]), .d_o (rnd[3]),
    .e_o (rnd[4]), .f_o (rnd[5]), .g_o (rnd[6]), .h_o (rnd[7])
  );

  assign w_new = small_sigma1(win_q[14]) + win_q[9] + small_sigma0(win_q[1]) + win_q[0];

  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    h_in_d      = h_in_q;
    vars_d      = vars_q;
    win_d       = win_q;
    digest_d    = digest_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          h_in_d  = in_state;
          vars_d  = in_state;
          win_d   = in_block;
          t_d     = 6'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        win_d = {win_q[1:15], w_new};
        if (t_q == 6'(ROUNDS - 1)) begin
          for (int i = 0; i < 8; i++) begin
            digest_d[i] = h_in_q[i] + rnd[i];
          end
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          vars_d = rnd;
          t_d    = t_q + 6'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      t_q         <= '0;
      h_in_q      <= '0;
      vars_q      <= '0;
      win_q       <= '0;
      digest_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      h_in_q      <= h_in_d;
      vars_q      <= vars_d;
      win_q       <= win_d;
      digest_q    <= digest_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Gated by rst_n so the upstream never sees ready while reset is held.
  assign in_ready   = rst_n & (state_q == IDLE);
  assign out_valid  = out_valid_q;
  assign out_digest = digest_q;

endmodule
